dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Data-memory responder for the core's load/store port: the slave end of the address / store-data /
//  byte-enable / load-data interface driven by the core.
//  Word-organised RAM with per-byte write lanes and a one-cycle registered read.
//  Post-reset hardware clear sequencer and out-of-range detection.
//  Sits between core data port and SoC; load data feeds the core's load sign-extension logic.
// PARAMETERS
//  DEPTH_WORDS     1024      number of 32-bit words; power of two, >=4
//  BASE_ADDR       32'h0     byte address of word 0; aligned to DEPTH_WORDS*4
//  CLEAR_ON_RESET  1         1: zero every word after reset before accepting traffic; 0: skip clear
// PORTS
//  clk         in   1    clock, all state on rising edge
//  rst         in   1    synchronous reset, active-high
//  addr        in   32   byte address from core ALU; bits[1:0] ignored for word select
//  wdata       in   32   store data, already lane-positioned by the core
//  we          in   4    byte write enables, we[i] writes wdata[8i+7:8i]; 4'b0000 = read only
//  rdata       out  32   load data for the address presented on the previous cycle
//  err         out  1    registered: previous-cycle access fell outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS)
//  ready       out  1    1 = clear done, accesses honoured; 0 = clearing
//  clr_idx     out  log2(DEPTH_WORDS)  current clear pointer (debug/verif visibility)
// BEHAVIOUR
//  Reset (rst=1 at edge): rdata=0, err=0, clr_idx=0.
//   ready=0, FSM->CLEAR if CLEAR_ON_RESET; else ready=1, FSM->RUN.
//   RAM contents not reset by rst itself.
//  FSM states:
//   CLEAR: each cycle write 32'h0 to word clr_idx, clr_idx++.
//    At clr_idx==DEPTH_WORDS-1 the write completes, then next state RUN, ready=1, clr_idx holds at its final value.
//    Clear takes exactly DEPTH_WORDS cycles after reset deasserts.
//    In CLEAR: we ignored (no core write lands), rdata=0, err=0.
//   RUN: permanent until rst.
//  Decode: in_range = (addr - BASE_ADDR) < 4*DEPTH_WORDS (32-bit unsigned compare, wrap-safe).
//   word index = (addr - BASE_ADDR)[log2(DEPTH_WORDS)+1:2].
//  Write (RUN, in_range, we!=0): only enabled byte lanes of the addressed word update at the edge; others keep value.
//  Read (RUN): every cycle, no enable.
//   rdata at edge N+1 = word addressed at edge N.
//   Latency 1 cycle, throughput 1 access/cycle, no back-pressure.
//  Simultaneous read/write same cycle, same word: write-first.
//   rdata = old word with the enabled lanes replaced by wdata.
//  Out-of-range: write dropped (no RAM change); next-cycle rdata=32'h0, err=1 for that one cycle only.
//  Back-to-back store then load to the same word on consecutive cycles returns the stored bytes.
//  No hazard buffering is needed: the array update is visible the next edge.
//  rst asserted mid-CLEAR: clr_idx restarts at 0, full clear reruns.
//  rst asserted in RUN: same restart, RAM contents re-cleared if CLEAR_ON_RESET.
//  X/unused addr bits[1:0] never affect lane selection; lanes come only from we.
// TESTING
//  1. Reset, DEPTH_WORDS=16: ready=0 for exactly 16 cycles, then 1.
//     Read all 16 words -> rdata=0, err=0 each.
//  2. RUN: addr=0x8, we=4'hF, wdata=0xDEADBEEF.
//     Next cycle addr=0x8, we=0 -> rdata=0xDEADBEEF.
//  3. Byte lanes: word 0x8=0xDEADBEEF, store we=4'b0100, wdata=0x00AA0000 -> reload gives 0xDEAABEEF.
//     Then we=4'b0011, wdata=0x00001234 -> 0xDEAA1234.
//  4. Same-cycle write-first: word 0x4=0x11223344; addr=0x4, we=4'b1000, wdata=0x99000000
//     -> next-cycle rdata=0x99223344.
//  5. Out-of-range (DEPTH_WORDS=16, BASE 0): addr=0x40, we=4'hF, wdata=0xFFFFFFFF
//     -> next cycle err=1, rdata=0; following cycle err=0; all words unchanged.
//     Also check addr=BASE_ADDR-4 wraps to out-of-range.
//  6. Reset mid-clear: assert rst at clr_idx=7.
//     -> clr_idx=0, ready=0, 16 more cycles to ready.
//     Core writes attempted during CLEAR leave RAM zero.

Source files
------------

// File: rtl/dmem_responder_if.sv
// Core data-port bundle: address, store data and byte enables toward the responder,
// plus load data, range error, ready and clear pointer back to the core.
interface dmem_responder_if #(
  parameter int unsigned IDX_W = 10
);
  logic [31:0]      addr;
  logic [31:0]      wdata;
  logic [3:0]       we;
  logic [31:0]      rdata;
  logic             err;
  logic             ready;
  logic [IDX_W-1:0] clr_idx;

  modport master (
    output addr,
    output wdata,
    output we,
    input  rdata,
    input  err,
    input  ready,
    input  clr_idx
  );

  modport slave (
    input  addr,
    input  wdata,
    input  we,
    output rdata,
    output err,
    output ready,
    output clr_idx
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM with per-byte write lanes, one-cycle registered write-first
// read, out-of-range detection and a post-reset clear sequencer.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS    = 1024,
  parameter logic [31:0] BASE_ADDR      = 32'h0,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  dmem_responder_if.slave io_bus
);

  localparam int unsigned     IdxW      = $clog2(DEPTH_WORDS);
  localparam logic [31:0]     SpanBytes = 32'(DEPTH_WORDS * 4);
  localparam logic [IdxW-1:0] LastIdx   = IdxW'(DEPTH_WORDS - 1);

  typedef enum logic [0:0] {StClear, StRun} state_e;

  state_e          r_state;
  state_e          w_state_d;
  logic            w_clearing;
  logic            w_ready;

  logic [31:0]     r_mem [DEPTH_WORDS];
  logic [31:0]     r_rdata;
  logic            r_err;
  logic [IdxW-1:0] r_clr_idx;

  logic [31:0]     w_off;
  logic            w_in_range;
  logic [IdxW-1:0] w_idx;
  logic [3:0]      w_wr_be;
  logic [IdxW-1:0] w_wr_idx;
  logic [31:0]     w_wr_data;
  logic [31:0]     w_merged;

  // Subtract-then-compare so addresses below BASE_ADDR wrap to large offsets and miss.
  assign w_off      = io_bus.addr - BASE_ADDR;
  assign w_in_range = (w_off < SpanBytes);
  assign w_idx      = w_off[IdxW+1:2];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= CLEAR_ON_RESET ? StClear : StRun;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StClear: if (r_clr_idx == LastIdx) w_state_d = StRun;
      StRun:   w_state_d = StRun;
    endcase
  end

  always_comb begin
    w_clearing = 1'b0;
    w_ready    = 1'b0;
    unique case (r_state)
      StClear: w_clearing = 1'b1;
      StRun:   w_ready    = 1'b1;
    endcase
  end

  // Single write port shared by the clear sequencer and core stores.
  always_comb begin
    w_wr_be   = 4'h0;
    w_wr_idx  = w_idx;
    w_wr_data = io_bus.wdata;
    if (!i_rst) begin
      if (w_clearing) begin
        w_wr_be   = 4'hF;
        w_wr_idx  = r_clr_idx;
        w_wr_data = 32'h0;
      end else if (w_in_range) begin
        w_wr_be = io_bus.we;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    for (int i = 0; i < 4; i++) begin
      if (w_wr_be[i]) begin
        r_mem[w_wr_idx][8*i +: 8] <= w_wr_data[8*i +: 8];
      end
    end
  end

  // Write-first read: stored word with this cycle's enabled store lanes patched in.
  always_comb begin
    w_merged = r_mem[w_idx];
    for (int i = 0; i < 4; i++) begin
      if (io_bus.we[i]) begin
        w_merged[8*i +: 8] = io_bus.wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rdata   <= 32'h0;
      r_err     <= 1'b0;
      r_clr_idx <= '0;
    end else if (w_clearing) begin
      r_rdata <= 32'h0;
      r_err   <= 1'b0;
      if (r_clr_idx != LastIdx) begin
        r_clr_idx <= r_clr_idx + IdxW'(1);
      end
    end else begin
      r_rdata <= w_in_range ? w_merged : 32'h0;
      r_err   <= ~w_in_range;
    end
  end

  assign io_bus.rdata   = r_rdata;
  assign io_bus.err     = r_err;
  assign io_bus.ready   = w_ready;
  assign io_bus.clr_idx = r_clr_idx;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (16 words, base 0): a byte-lane memory model feeds a
// scoreboard queue that is checked one cycle after each access is driven.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 16;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  dmem_responder_if #(.IDX_W(4)) bus ();

  dmem_responder #(
    .DEPTH_WORDS   (DEPTH),
    .BASE_ADDR     (32'h0),
    .CLEAR_ON_RESET(1'b1)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .io_bus(bus)
  );

  typedef struct {
    logic [31:0] d;
    logic        e;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [DEPTH];
  int          n_assert = 0;
  int          n_fail   = 0;
  int          cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic collect();
    exp_t x;
    if (sb.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL scoreboard_underflow: observed 0 entries expected 1");
    end else begin
      x = sb.pop_front();
      chk({x.tag, "_rdata"}, bus.rdata, x.d);
      chk({x.tag, "_err"}, {31'h0, bus.err}, {31'h0, x.e});
    end
  endtask

  // One RUN-mode access; expectation comes from the model (write-first on stores).
  task automatic acc(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd,
                     input string tag);
    exp_t        x;
    logic [31:0] w;
    bus.addr  = a;
    bus.we    = we;
    bus.wdata = wd;
    if (a < 32'(DEPTH * 4)) begin
      w = model[a[5:2]];
      for (int i = 0; i < 4; i++) if (we[i]) w[8*i +: 8] = wd[8*i +: 8];
      model[a[5:2]] = w;
      x.d = w;
      x.e = 1'b0;
    end else begin
      x.d = 32'h0;
      x.e = 1'b1;
    end
    x.tag = tag;
    sb.push_back(x);
    @(negedge clk);
    collect();
  endtask

  // Load with a hand-written expected value.
  task automatic rd_exp(input logic [31:0] a, input logic [31:0] exp, input string tag);
    exp_t x;
    bus.addr  = a;
    bus.we    = 4'h0;
    bus.wdata = 32'h0;
    x.d   = exp;
    x.e   = 1'b0;
    x.tag = tag;
    sb.push_back(x);
    @(negedge clk);
    collect();
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < DEPTH; i++) acc(32'(i * 4), 4'h0, 32'h0, tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected end of test");
    $fatal(1, "timeout");
  end

  initial begin
    rst       = 1'b1;
    bus.addr  = 32'h0;
    bus.we    = 4'h0;
    bus.wdata = 32'h0;
    for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;

    // Reset state and clear length.
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", {31'h0, bus.ready}, 32'h0);
    chk("rst_clr_idx", {28'h0, bus.clr_idx}, 32'h0);
    chk("rst_rdata", bus.rdata, 32'h0);
    chk("rst_err", {31'h0, bus.err}, 32'h0);
    rst = 1'b0;
    cnt = 0;
    while (bus.ready !== 1'b1 && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    chk("clear_cycles", 32'(cnt), 32'd16);
    chk("clr_idx_final", {28'h0, bus.clr_idx}, 32'd15);
    read_all("post_clear");

    // Full-word store then load.
    acc(32'h8, 4'hF, 32'hDEADBEEF, "st_full");
    rd_exp(32'h8, 32'hDEADBEEF, "ld_full");

    // Byte lanes.
    acc(32'h8, 4'b0100, 32'h00AA0000, "st_lane2");
    rd_exp(32'h8, 32'hDEAABEEF, "ld_lane2");
    acc(32'h8, 4'b0011, 32'h00001234, "st_lane10");
    rd_exp(32'h8, 32'hDEAA1234, "ld_lane10");

    // Same-cycle write-first, and addr[1:0] not steering lanes.
    acc(32'h4, 4'hF, 32'h11223344, "st_w1");
    acc(32'h4, 4'b1000, 32'h99000000, "wf_lane3");
    rd_exp(32'h4, 32'h99223344, "ld_wf");
    acc(32'h6, 4'b0001, 32'h000000AB, "st_unaligned");
    rd_exp(32'h4, 32'h992233AB, "ld_unaligned");

    // Out-of-range: dropped store, single-cycle err, wrap below base.
    acc(32'h40, 4'hF, 32'hFFFFFFFF, "oor_top");
    acc(32'h8, 4'h0, 32'h0, "after_oor");
    acc(32'hFFFF_FFFC, 4'hF, 32'hFFFFFFFF, "oor_wrap");
    acc(32'h3C, 4'h0, 32'h0, "last_word");
    read_all("after_oor_all");

    // Reset from RUN, then reset again mid-clear while the core tries to store.
    rst      = 1'b1;
    bus.we   = 4'h0;
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    while (bus.clr_idx !== 4'd7 && cnt < 100) begin
      bus.addr  = 32'h20;
      bus.we    = 4'hF;
      bus.wdata = 32'hFFFFFFFF;
      cnt++;
      @(negedge clk);
    end
    chk("reach_idx7", 32'(cnt), 32'd7);
    rst = 1'b1;
    @(negedge clk);
    chk("midclr_clr_idx", {28'h0, bus.clr_idx}, 32'h0);
    chk("midclr_ready", {31'h0, bus.ready}, 32'h0);
    rst = 1'b0;
    cnt = 0;
    while (bus.ready !== 1'b1 && cnt < 100) begin
      bus.addr  = 32'(cnt * 4);
      bus.we    = 4'hF;
      bus.wdata = 32'hFFFFFFFF;
      cnt++;
      @(negedge clk);
      chk("clear_rdata", bus.rdata, 32'h0);
      chk("clear_err", {31'h0, bus.err}, 32'h0);
    end
    chk("reclear_cycles", 32'(cnt), 32'd16);
    bus.we = 4'h0;
    for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
    read_all("post_reclear");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
